mult32_shift_add: RTL and testbench



---
 rtl/mult32_shift_add.sv | 168 ++++++++++++++++
 tb/tb_mult32_shift_add.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult32_shift_add.sv
// Multi-cycle 32x32 shift-add multiplier driving an external 32-bit ripple adder.
// Define MULT32_SIGNED_EN to add signed_op and two's-complement correction steps.
module mult32_shift_add (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] mcand,
   input  logic [31:0] mplier,
`ifdef MULT32_SIGNED_EN
   input  logic        signed_op,
`endif
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_cin,
   input  logic [31:0] add_sum,
   input  logic        add_cout
);

   localparam int unsigned ITERS = 32;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned ST_W  = 3;

   localparam logic [ST_W-1:0] IDLE  = 3'd0;
   localparam logic [ST_W-1:0] CALC  = 3'd1;
   localparam logic [ST_W-1:0] DONE  = 3'd2;
`ifdef MULT32_SIGNED_EN
   localparam logic [ST_W-1:0] CORR1 = 3'd3;
   localparam logic [ST_W-1:0] CORR2 = 3'd4;
`endif

   logic [ST_W-1:0]  state_q, state_d;
   logic [31:0]      m_q, m_d;
   logic [31:0]      p_hi_q, p_hi_d;
   logic [31:0]      p_lo_q, p_lo_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [63:0]      product_q, product_d;
`ifdef MULT32_SIGNED_EN
   logic [31:0]      q_q, q_d;
   logic             sgn_q, sgn_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         m_q       <= '0;
         p_hi_q    <= '0;
         p_lo_q    <= '0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
`ifdef MULT32_SIGNED_EN
         q_q       <= '0;
         sgn_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_hi_q    <= p_hi_d;
         p_lo_q    <= p_lo_d;
         count_q   <= count_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
`ifdef MULT32_SIGNED_EN
         q_q       <= q_d;
         sgn_q     <= sgn_d;
`endif
      end
   end

   // Next-state, datapath and adder operand decode (registers only feed add_*)
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_hi_d    = p_hi_q;
      p_lo_d    = p_lo_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
`ifdef MULT32_SIGNED_EN
      q_d       = q_q;
      sgn_d     = sgn_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (start) begin
               m_d     = mcand;
               p_hi_d  = '0;
               p_lo_d  = mplier;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = CALC;
`ifdef MULT32_SIGNED_EN
               q_d     = mplier;
               sgn_d   = signed_op;
`endif
            end
         end
         CALC: begin
            add_a   = p_hi_q;
            add_b   = p_lo_q[0] ? m_q : '0;
            // Carry-out is the 33rd bit of the partial sum and shifts into P_hi[31]
            {p_hi_d, p_lo_d} = {add_cout, add_sum, p_lo_q[31:1]};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(ITERS - 1)) begin
`ifdef MULT32_SIGNED_EN
               if (sgn_q) begin
                  state_d = CORR1;
               end else begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  product_d = {add_cout, add_sum, p_lo_q[31:1]};
               end
`else
               state_d   = DONE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               product_d = {add_cout, add_sum, p_lo_q[31:1]};
`endif
            end
         end
`ifdef MULT32_SIGNED_EN
         // Subtract the sign-weighted cross terms from the upper word, mod 2^32
         CORR1: begin
            add_a   = p_hi_q;
            add_b   = q_q[31] ? ~m_q : '0;
            add_cin = q_q[31];
            p_hi_d  = add_sum;
            state_d = CORR2;
         end
         CORR2: begin
            add_a     = p_hi_q;
            add_b     = m_q[31] ? ~q_q : '0;
            add_cin   = m_q[31];
            p_hi_d    = add_sum;
            state_d   = DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            product_d = {add_sum, p_lo_q};
         end
`endif
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_mult32_shift_add.sv
// Directed self-checking bench for mult32_shift_add; models the external ripple adder.
module tb_mult32_shift_add;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] mcand;
   logic [31:0] mplier;
`ifdef MULT32_SIGNED_EN
   logic        signed_op;
`endif
   logic        busy;
   logic        done;
   logic [63:0] product;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_cin;
   logic [31:0] add_sum;
   logic        add_cout;

   int errors;
   int checks;

   mult32_shift_add dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mcand    (mcand),
      .mplier   (mplier),
`ifdef MULT32_SIGNED_EN
      .signed_op(signed_op),
`endif
      .busy     (busy),
      .done     (done),
      .product  (product),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Shared 32-bit adder model
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Hold start across one rising edge (T0), then confirm busy
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   // Count edges until done is seen; check latency, product and busy
   task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_prod);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < exp_lat + 8) begin
         @(posedge clk);
         #1;
         n++;
         if (done) seen = 1'b1;
      end
      chk({tag, "_lat"}, seen ? 64'(n) : 64'hDEAD, 64'(exp_lat));
      chk({tag, "_prod"}, product, exp_prod);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      bit saw_done;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      mcand  = '0;
      mplier = '0;
`ifdef MULT32_SIGNED_EN
      signed_op = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_add", {31'd0, add_a, add_cin}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 3*5, plus first-iteration operands and single-cycle done
      @(negedge clk);
      issue(32'd3, 32'd5);
      chk("calc_add_a", 64'(add_a), 64'd0);
      chk("calc_add_b", 64'(add_b), 64'd3);
      wait_done("m3x5", 32, 64'h0000_0000_0000_000F);
      @(posedge clk);
      #1;
      chk("done_pulse_width", 64'(done), 64'd0);
      chk("idle_add_a", 64'(add_a), 64'd0);

      // All-ones operands need the carry-out capture
      @(negedge clk);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mffxff", 32, 64'hFFFF_FFFE_0000_0001);
      @(posedge clk);
      #1;
      chk("idle_add_b", 64'(add_b), 64'd0);
      chk("idle_add_cin", 64'(add_cin), 64'd0);

      // Start while busy at T10 is ignored
      @(negedge clk);
      issue(32'h1234, 32'h10);
      repeat (9) @(posedge clk);
      #1;
      start  = 1'b1;
      mcand  = 32'd7;
      mplier = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("ignore_busy_start", 22, 64'h0000_0000_0001_2340);

      // Back-to-back: start accepted in the done cycle
      issue(32'd7, 32'd9);
      wait_done("back_to_back", 32, 64'd63);

      // Reset mid-operation aborts without a done pulse
      @(negedge clk);
      issue(32'hFFFF, 32'hFFFF);
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_product", product, 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
      @(negedge clk);
      issue(32'd2, 32'd2);
      wait_done("after_abort", 32, 64'd4);

      // Zero multiplicand
      @(negedge clk);
      issue(32'd0, 32'hDEAD_BEEF);
      wait_done("zero_mcand", 32, 64'd0);

`ifdef MULT32_SIGNED_EN
      @(negedge clk);
      signed_op = 1'b1;
      issue(32'hFFFF_FFFD, 32'd5);
      wait_done("s_neg3x5", 34, 64'hFFFF_FFFF_FFFF_FFF1);
      @(negedge clk);
      issue(32'h8000_0000, 32'h8000_0000);
      wait_done("s_minxmin", 34, 64'h4000_0000_0000_0000);
      @(negedge clk);
      signed_op = 1'b0;
      issue(32'd3, 32'd5);
      wait_done("s_off_3x5", 32, 64'd15);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
